// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - round-robin request arbiter for a shared single-port DRAM (optional range check: DRAM_ADDR_CHECK_EN)
module dram_arbiter #(
    parameter int NUM_CORES = 2,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_DEPTH = 1025
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CORES-1:0]        req_valid,
    output logic [NUM_CORES-1:0]        req_ready,
    input  logic [NUM_CORES-1:0]        req_we,
    input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
    input  logic [NUM_CORES*DATA_W-1:0] req_wdata,
    output logic [NUM_CORES-1:0]        resp_valid,
    output logic [DATA_W-1:0]           resp_rdata,
    output logic                        resp_err,
    output logic                        mem_write_en,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_data_in,
    input  logic [DATA_W-1:0]           mem_data_out
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   rr_ptr_nxt;
    logic               grant_found;
    int                 cand;

    logic [PTR_W-1:0]   cmd_core;
    logic               cmd_we;
    logic [ADDR_W-1:0]  cmd_addr;
    logic [DATA_W-1:0]  cmd_wdata;
    logic [DATA_W-1:0]  rdata_q;
    logic               addr_err;

`ifdef DRAM_ADDR_CHECK_EN
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(MEM_DEPTH);
    logic cmd_err;
    logic grant_err;
    assign grant_err = {1'b0, req_addr[grant_idx*ADDR_W +: ADDR_W]} >= DEPTH_LIM;
    assign addr_err  = cmd_err;
`else
    assign addr_err  = 1'b0;
`endif

    // Round-robin search: first valid request at or after rr_ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = 0; i < NUM_CORES; i++) begin
            cand = (int'(rr_ptr) + i) % NUM_CORES;
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(cand);
            end
        end
        rr_ptr_nxt = PTR_W'((int'(grant_idx) + 1) % NUM_CORES);
    end

    // Next-state logic and accept handshake; requests are only taken in IDLE and never while in reset.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant_idx] = rst_n;
                    state_nxt            = ACCESS;
                end
            end
            ACCESS:  state_nxt = cmd_we ? RESP : CAPTURE;
            CAPTURE: state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // DRAM port follows the command registers; write strobe only in ACCESS of an in-range write.
    always_comb begin
        mem_addr     = cmd_addr;
        mem_data_in  = cmd_wdata;
        mem_write_en = (state == ACCESS) && cmd_we && !addr_err;
        resp_valid   = '0;
        if (state == RESP) begin
            resp_valid[cmd_core] = 1'b1;
        end
        resp_rdata   = (state == RESP) ? rdata_q : '0;
        resp_err     = (state == RESP) && addr_err;
    end

    // State, round-robin pointer and command/response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cmd_core  <= '0;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            rdata_q   <= '0;
`ifdef DRAM_ADDR_CHECK_EN
            cmd_err   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (state == IDLE && grant_found) begin
                rr_ptr    <= rr_ptr_nxt;
                cmd_core  <= grant_idx;
                cmd_we    <= req_we[grant_idx];
                cmd_addr  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
                cmd_wdata <= req_wdata[grant_idx*DATA_W +: DATA_W];
                rdata_q   <= '0;
`ifdef DRAM_ADDR_CHECK_EN
                cmd_err   <= grant_err;
`endif
            end
            if (state == CAPTURE) begin
                rdata_q <= addr_err ? '0 : mem_data_out;
            end
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - self-checking bench for dram_arbiter
module tb_dram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic        mem_write_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;

    int passed = 0;
    int total  = 0;

`ifdef DRAM_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        int          core;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [9];

    logic [15:0] mem [4096];

    dram_arbiter #(.NUM_CORES(2), .ADDR_W(16), .DATA_W(16), .MEM_DEPTH(1025)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_write_en (mem_write_en),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    always #5 clk = ~clk;

    // DRAM model: write on the edge, read data one cycle after the address is presented.
    always @(posedge clk) begin
        if (mem_write_en) mem[mem_addr[11:0]] <= mem_data_in;
        mem_data_out <= mem[mem_addr[11:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
        else passed++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_req(input vec_t v);
        int   n;
        int   lat;
        int   wecnt;
        bit   got;
        @(negedge clk);
        req_valid[v.core] = 1'b1;
        req_we[v.core] = v.we;
        req_addr[v.core*16 +: 16] = v.addr;
        req_wdata[v.core*16 +: 16] = v.wdata;
        #1;
        n = 0;
        while (!req_ready[v.core] && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("accept", 32'(req_ready), 32'(1) << v.core);
        @(posedge clk); #1;
        req_valid[v.core] = 1'b0;
        @(negedge clk);
        chk("access_we", 32'(mem_write_en), 32'(v.we && !v.exp_err));
        chk("access_addr", 32'(mem_addr), 32'(v.addr));
        if (v.we) chk("access_wdata", 32'(mem_data_in), 32'(v.wdata));
        got = 1'b0; lat = 1; wecnt = 0;
        while (!got && lat < 6) begin
            @(negedge clk); lat++;
            if (mem_write_en) wecnt++;
            if (resp_valid != 2'b00) got = 1'b1;
        end
        chk("latency", 32'(lat), v.we ? 32'd2 : 32'd3);
        chk("resp_valid", 32'(resp_valid), 32'(1) << v.core);
        chk("resp_rdata", 32'(resp_rdata), 32'(v.exp_rdata));
        chk("resp_err", 32'(resp_err), 32'(v.exp_err));
        chk("we_single_pulse", 32'(wecnt), 32'd0);
    endtask

    initial begin
        int grants;
        int exp_next;
        int cyc;
        int bad;
        int q[$];

        for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
        mem_data_out = 16'h0;
        req_we = 2'b00; req_addr = '0; req_wdata = '0;

        vecs[0] = '{0, 1'b1, 16'd5,    16'h1234, 16'h0000, 1'b0};
        vecs[1] = '{1, 1'b0, 16'd5,    16'h0000, 16'h1234, 1'b0};
        vecs[2] = '{1, 1'b1, 16'd7,    16'hABCD, 16'h0000, 1'b0};
        vecs[3] = '{0, 1'b0, 16'd7,    16'h0000, 16'hABCD, 1'b0};
        vecs[4] = '{0, 1'b1, 16'd1024, 16'h5555, 16'h0000, 1'b0};
        vecs[5] = '{1, 1'b0, 16'd1024, 16'h0000, 16'h5555, 1'b0};
        vecs[6] = '{0, 1'b1, 16'd2000, 16'h9999, 16'h0000, CHK};
        vecs[7] = '{1, 1'b0, 16'd2000, 16'h0000, CHK ? 16'h0000 : 16'h9999, CHK};
        vecs[8] = '{0, 1'b0, 16'd0,    16'h0000, 16'h0000, 1'b0};

        // Reset held with all requests asserted.
        rst_n = 1'b0;
        req_valid = 2'b11;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_mem_we", 32'(mem_write_en), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_data_in", 32'(mem_data_in), 32'd0);
        req_valid = 2'b00;
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) do_req(vecs[i]);

        // Both cores request continuously: grants alternate from core 0.
        do_reset();
        @(negedge clk);
        req_we = 2'b00;
        req_addr = {16'd7, 16'd5};
        req_valid = 2'b11;
        #1;
        grants = 0; exp_next = 0; cyc = 0;
        if (req_ready != 2'b00) begin
            chk("rr_grant", 32'(req_ready), 32'(1) << exp_next);
            q.push_back(exp_next); exp_next ^= 1; grants++;
        end
        while (grants < 8 && cyc < 200) begin
            @(negedge clk); #1; cyc++;
            if (resp_valid != 2'b00) begin
                chk("rr_resp", 32'(resp_valid), (q.size() > 0) ? (32'(1) << q[0]) : 32'd0);
                if (q.size() > 0) begin
                    chk("rr_rdata", 32'(resp_rdata), (q[0] == 0) ? 32'h1234 : 32'hABCD);
                    void'(q.pop_front());
                end
            end
            if (req_ready != 2'b00) begin
                chk("rr_grant", 32'(req_ready), 32'(1) << exp_next);
                q.push_back(exp_next); exp_next ^= 1; grants++;
            end
        end
        chk("rr_grant_count", 32'(grants), 32'd8);
        @(posedge clk); #1;
        req_valid = 2'b00;
        cyc = 0;
        while (q.size() > 0 && cyc < 10) begin
            @(negedge clk); cyc++;
            if (resp_valid != 2'b00) begin
                chk("rr_resp", 32'(resp_valid), 32'(1) << q[0]);
                void'(q.pop_front());
            end
        end
        chk("rr_drain", 32'(q.size()), 32'd0);

        // Reset asserted while a read sits in CAPTURE.
        do_reset();
        @(negedge clk);
        req_we[0] = 1'b0;
        req_addr[15:0] = 16'd5;
        req_valid = 2'b01;
        #1;
        chk("midrst_accept", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_no_resp", 32'(resp_valid), 32'd0);
        rst_n = 1'b1;
        req_valid = 2'b11;
        #1;
        chk("midrst_idle_rrptr0", 32'(req_ready), 32'd1);
        req_valid = 2'b00;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid != 2'b00) bad++;
        end
        chk("midrst_no_late_resp", 32'(bad), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
